// File: rtl/egg_timer_pkg.sv
// Shared state encoding for the egg timer front-panel controller.
package egg_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_RING  = 2'b11
  } state_e;

endpackage

// File: rtl/egg_timer_ctrl_buzz_timer.sv
// Counts sec_tick pulses while the buzzer sounds; done fires on the tick that
// reaches BUZZ_SECS.
module buzz_timer #(
  parameter int BUZZ_SECS = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic tick_i,
  output logic done_o
);

  localparam int CW = $clog2(BUZZ_SECS + 1);
  localparam logic [CW-1:0] LAST = CW'(BUZZ_SECS - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign done_o = !clr_i && tick_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || done_o) begin
      cnt_d = '0;
    end else if (tick_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/egg_timer_ctrl.sv
// Front-panel sequencer for alarm_fsm: target-count entry, run/pause/clear
// control and a bounded buzzer after the alarm fires.
module egg_timer_ctrl
  import egg_timer_pkg::*;
#(
  parameter int SIZE        = 4,
  parameter int DEFAULT_MAX = 5,
  parameter int BUZZ_SECS   = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            btn_start,
  input  logic            btn_stop,
  input  logic            btn_inc,
  input  logic            btn_dec,
  input  logic            sec_tick,
  input  logic [SIZE-1:0] count,
  input  logic            alarm,
  output logic [SIZE-1:0] max,
  output logic            enable,
  output logic            timer_clr,
  output logic            buzzer,
  output logic [SIZE-1:0] remaining,
  output logic [1:0]      state
);

  localparam logic [SIZE-1:0] MAX_TOP = '1;
  localparam logic [SIZE-1:0] MAX_BOT = SIZE'(1);
  localparam logic [SIZE-1:0] MAX_DEF = SIZE'(DEFAULT_MAX);

  state_e          state_q, state_d;
  logic [SIZE-1:0] max_q, max_d;
  logic [SIZE-1:0] rem_q, rem_d;
  logic            enable_q, enable_d;
  logic            clr_q, clr_d;
  logic            buzzer_q, buzzer_d;
  logic            buzz_done;

  buzz_timer #(
    .BUZZ_SECS(BUZZ_SECS)
  ) u_buzz (
    .clk   (clk),
    .rst   (rst),
    .clr_i (state_q != ST_RING),
    .tick_i(sec_tick),
    .done_o(buzz_done)
  );

  always_comb begin
    state_d = state_q;
    max_d   = max_q;
    clr_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // btn_stop does nothing here but still outranks start and inc/dec
        if (!btn_stop) begin
          if (btn_start) begin
            state_d = ST_RUN;
            clr_d   = 1'b1;
          end else if (btn_inc && !btn_dec && max_q != MAX_TOP) begin
            max_d = max_q + 1'b1;
          end else if (btn_dec && !btn_inc && max_q != MAX_BOT) begin
            max_d = max_q - 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (btn_stop) begin
          state_d = ST_PAUSE;
        end else if (alarm) begin
          state_d = ST_RING;
        end
      end
      ST_PAUSE: begin
        if (btn_stop) begin
          state_d = ST_IDLE;
          clr_d   = 1'b1;
        end else if (btn_start) begin
          state_d = ST_RUN;
        end
      end
      ST_RING: begin
        if (btn_stop || buzz_done) begin
          state_d = ST_IDLE;
          clr_d   = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    enable_d = (state_d == ST_RUN);
    buzzer_d = (state_d == ST_RING);

    // Display follows the state being entered so it lines up with the other outputs
    unique case (state_d)
      ST_IDLE: rem_d = max_d;
      ST_RING: rem_d = '0;
      default: rem_d = (count > max_q) ? '0 : max_q - count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      max_q    <= MAX_DEF;
      rem_q    <= MAX_DEF;
      enable_q <= 1'b0;
      clr_q    <= 1'b1;
      buzzer_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      max_q    <= max_d;
      rem_q    <= rem_d;
      enable_q <= enable_d;
      clr_q    <= clr_d;
      buzzer_q <= buzzer_d;
    end
  end

  assign max       = max_q;
  assign remaining = rem_q;
  assign enable    = enable_q;
  assign timer_clr = clr_q;
  assign buzzer    = buzzer_q;
  assign state     = state_q;

endmodule

// File: doc/egg_timer_ctrl.md
Name: egg_timer_ctrl

Overview:
Front-panel controller that sequences the alarm_fsm countdown datapath. It takes pre-debounced single-cycle button pulses and lets the user set the target count. It starts, pauses and clears alarm_fsm through its enable/max/clear inputs, then drives a buzzer for a bounded time once alarm fires. It sits between the button synchronisers and alarm_fsm in the egg timer top level.

Parameters:
SIZE, 4, width of max/count/remaining; must match alarm_fsm SIZE
DEFAULT_MAX, 5, max value loaded at reset; must be 1..2^SIZE-1
BUZZ_SECS, 3, number of sec_tick pulses the buzzer sounds before auto-return to IDLE; must be >= 1

Ports:
clk  in  1  controller clock; all logic on posedge
rst  in  1  active-low synchronous reset
btn_start  in  1  one-cycle pulse: start/resume
btn_stop  in  1  one-cycle pulse: pause/cancel/silence
btn_inc  in  1  one-cycle pulse: max+1 (IDLE only)
btn_dec  in  1  one-cycle pulse: max-1 (IDLE only)
sec_tick  in  1  one-cycle pulse per second; used for buzzer timing
count  in  SIZE  current count from alarm_fsm
alarm  in  1  alarm flag from alarm_fsm
max  out  SIZE  target count to alarm_fsm
enable  out  1  count enable to alarm_fsm
timer_clr  out  1  active-high clear to alarm_fsm rst input
buzzer  out  1  buzzer drive
remaining  out  SIZE  display value
state  out  2  current state encoding

Behaviour:
- Reset (rst==0 at posedge clk) forces the following: state=IDLE, max=DEFAULT_MAX, enable=0, timer_clr=1, buzzer=0, remaining=DEFAULT_MAX, buzz counter=0. Reset mid-operation aborts any state on the same edge.
- All outputs are registered. Any input event takes effect at the next posedge; each output reflects it 1 cycle later.
- timer_clr is 1 only in the cycle after reset release and as a 1-cycle pulse on every clearing transition (marked [clr]). Otherwise it is 0.
- Same-cycle priority: btn_stop > alarm > btn_start > inc/dec. btn_inc and btn_dec together produce no change.
- IDLE (2'b00):
  - btn_inc sets max=min(max+1, 2^SIZE-1). btn_dec sets max=max(max-1, 1). Both saturate and never wrap.
  - btn_start goes to RUN [clr] with enable=1. btn_stop has no effect.
- RUN (2'b01):
  - enable=1.
  - alarm==1 goes to RING: enable=0, buzzer=1, buzz counter=0.
  - btn_stop goes to PAUSE with enable=0, count retained (no clr).
  - inc/dec/start are ignored.
- PAUSE (2'b10):
  - enable=0.
  - btn_start goes to RUN, enable=1, no clr (resume).
  - btn_stop goes to IDLE [clr].
  - inc/dec are ignored.
- RING (2'b11):
  - buzzer=1.
  - Each sec_tick increments the buzz counter.
  - When the tick that makes the counter equal BUZZ_SECS arrives, go to IDLE [clr] with buzzer=0.
  - btn_stop goes to IDLE [clr] immediately.
  - btn_start/inc/dec are ignored.
- remaining:
  - IDLE: max.
  - RUN/PAUSE: max-count, unsigned SIZE bits, clamped to 0 if count>max.
  - RING: 0.
- max is held constant outside IDLE. alarm_fsm never sees max change mid-count.
- alarm asserted while in IDLE or PAUSE is ignored; a stale flag is removed by the next clr.

Decomposition:
- Shared package egg_timer_pkg holds:
  - state encodings ST_IDLE=2'b00, ST_RUN=2'b01, ST_PAUSE=2'b10, ST_RING=2'b11;
  - the 2-bit state typedef.
- One sub-module, buzz_timer: a tick counter with clear and a done flag, parameterised by BUZZ_SECS.
- The FSM, max register and remaining logic live in egg_timer_ctrl.

Test Plan:
1. Reset with SIZE=4, DEFAULT_MAX=5 -> max=5, remaining=5, enable=0, buzzer=0, state=00, timer_clr=1 in the first cycle after release, 0 thereafter.
2. In IDLE: 12 btn_inc pulses, then 20 btn_dec pulses -> max reaches 15 and saturates; max then reaches 1 and saturates. An inc+dec pulse in the same cycle leaves max unchanged.
3. max=5, btn_start -> one timer_clr pulse, enable=1, state=01. Drive count 0..5 then alarm=1 -> state=11, enable=0, buzzer=1. After 3 sec_ticks -> state=00, buzzer=0, one timer_clr pulse.
4. RUN at count=2, btn_stop -> state=10, enable=0, remaining=3, no timer_clr. Then btn_start -> state=01, enable=1, no timer_clr. Then btn_stop twice -> state=00 with one timer_clr pulse.
5. RING after 1 sec_tick, btn_stop -> state=00, buzzer=0 on the next cycle. In RUN, btn_stop and alarm in the same cycle -> state=10, buzzer stays 0.
6. rst low for one cycle while in RUN with count=3 -> all outputs return to reset values; btn_inc in RUN leaves max unchanged.
